fetch_bp_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC register and a 2-bit saturating-counter branch history table (BHT).
- Drives the instruction-memory address and produces the registered IF/ID pipeline fields (pc, instruction, bp_state) consumed by decode.
- Accepts stall from hazard detection, and a redirect plus predictor update from the branch-resolution logic in EX.

---
 rtl/fetch_bp_stage_if.sv | 26 ++
 rtl/fetch_bp_stage.sv | 98 +++++++++
 tb/tb_fetch_bp_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_bp_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction memory,
// hazard stall, EX redirect/predictor update, and the IF/ID pipeline fields.
interface fetch_bp_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [1:0]  if_id_bp_state;
    logic        if_id_pred_taken;

    modport slave (
        output imem_addr, if_id_pc, if_id_instr, if_id_bp_state, if_id_pred_taken,
        input  imem_rdata, stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken
    );

    modport master (
        input  imem_addr, if_id_pc, if_id_instr, if_id_bp_state, if_id_pred_taken,
        output imem_rdata, stall, redirect_valid, redirect_pc, upd_valid, upd_pc, upd_taken
    );
endinterface

// File: rtl/fetch_bp_stage.sv
// RV32I instruction-fetch stage: PC register, 2-bit saturating BHT predictor,
// and the registered IF/ID fields handed to decode.
module fetch_bp_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned BHT_IDX_BITS = 6,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input logic             clk,
    input logic             rst,
    fetch_bp_stage_if.slave bus
);
    localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [1:0]  BHT_INIT    = 2'b01;

    logic [31:0]             pc;
    logic [31:0]             next_pc;
    logic [31:0]             target;
    logic [31:0]             b_imm;
    logic [31:0]             j_imm;
    logic [31:0]             instr;
    logic [BHT_IDX_BITS-1:0] fetch_idx;
    logic [BHT_IDX_BITS-1:0] upd_idx;
    logic [1:0]              bht [BHT_ENTRIES];
    logic [1:0]              fetch_ctr;
    logic                    pred_taken;
    logic                    unused_upd_pc_bits;

    assign instr     = bus.imem_rdata;
    assign fetch_idx = pc[BHT_IDX_BITS+1:2];
    assign upd_idx   = bus.upd_pc[BHT_IDX_BITS+1:2];
    assign fetch_ctr = bht[fetch_idx];
    assign bus.imem_addr = pc;

    // BHT is untagged, so the upper and byte-offset PC bits never matter.
    assign unused_upd_pc_bits = ^{bus.upd_pc[31:BHT_IDX_BITS+2], bus.upd_pc[1:0]};

    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        pred_taken = 1'b0;
        target     = pc + 32'd4;
        case (instr[6:0])
            OP_BRANCH: begin
                pred_taken = fetch_ctr[1];
                target     = pc + b_imm;
            end
            OP_JAL: begin
                pred_taken = 1'b1;
                target     = pc + j_imm;
            end
            default: ;
        endcase
        next_pc = pred_taken ? target : pc + 32'd4;
    end

    // Redirect outranks stall: a flush must land even while decode is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc                   <= RESET_PC;
            bus.if_id_pc         <= '0;
            bus.if_id_instr      <= NOP_INSTR;
            bus.if_id_bp_state   <= '0;
            bus.if_id_pred_taken <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc                   <= bus.redirect_pc;
            bus.if_id_pc         <= '0;
            bus.if_id_instr      <= NOP_INSTR;
            bus.if_id_bp_state   <= '0;
            bus.if_id_pred_taken <= 1'b0;
        end else if (!bus.stall) begin
            pc                   <= next_pc;
            bus.if_id_pc         <= pc;
            bus.if_id_instr      <= instr;
            bus.if_id_bp_state   <= fetch_ctr;
            bus.if_id_pred_taken <= pred_taken;
        end
    end

    // Training is independent of stall/redirect; fetch sees the old value this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (bus.upd_valid) begin
            if (bus.upd_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                end
            end else if (bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_bp_stage.sv
// Directed bench for fetch_bp_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares them on every falling edge.
module tb_fetch_bp_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA  = 32'h0010_0093;
    localparam logic [31:0] IB  = 32'h0020_0113;
    localparam logic [31:0] IC  = 32'h0030_0193;
    localparam logic [31:0] BR  = 32'hFE00_0CE3; // beq x0,x0,-8
    localparam logic [31:0] JL  = 32'h1000_006F; // jal x0,+0x100

    typedef struct {
        int          step;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  bp;
        logic        pred;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    exp_t expq[$];
    exp_t cur;

    fetch_bp_stage_if bus();

    fetch_bp_stage #(
        .RESET_PC    (32'h0000_0000),
        .BHT_IDX_BITS(6),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                cur = expq.pop_front();
                chk("imem_addr", cur.step, bus.imem_addr, cur.addr);
                chk("if_id_pc", cur.step, bus.if_id_pc, cur.pc);
                chk("if_id_instr", cur.step, bus.if_id_instr, cur.instr);
                chk("if_id_bp_state", cur.step, {30'd0, bus.if_id_bp_state}, {30'd0, cur.bp});
                chk("if_id_pred_taken", cur.step, {31'd0, bus.if_id_pred_taken}, {31'd0, cur.pred});
            end
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] p, input logic [31:0] i,
                            input logic [1:0] b, input logic t);
        exp_t e;
        e.step  = step_no;
        e.addr  = a;
        e.pc    = p;
        e.instr = i;
        e.bp    = b;
        e.pred  = t;
        expq.push_back(e);
    endtask

    // Called just after a falling edge; drives inputs for one rising edge.
    task automatic step(input logic st, input logic rv, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] ins,
                        input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei,
                        input logic [1:0] eb, input logic et);
        step_no++;
        bus.stall          = st;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.imem_rdata     = ins;
        @(posedge clk);
        push_exp(ea, ep, ei, eb, et);
        @(negedge clk);
    endtask

    task automatic reset_mid();
        step_no++;
        #1 rst = 1'b0;
        @(posedge clk);
        push_exp(32'h0, 32'h0, NOP, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_taken      = 1'b0;
        bus.imem_rdata     = NOP;
        repeat (2) @(posedge clk);
        push_exp(32'h0, 32'h0, NOP, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // sequential fetch 0,4,8,...
        step(0, 0, 0, 0, 0, 0, IA, 32'h04, 32'h00, IA, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, IB, 32'h08, 32'h04, IB, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, IC, 32'h0C, 32'h08, IC, 2'b01, 0);
        step(0, 0, 0, 0, 0, 0, IA, 32'h10, 32'h0C, IA, 2'b01, 0);
        // backward branch at 0x10, weakly not-taken
        step(0, 0, 0, 0, 0, 0, BR, 32'h14, 32'h10, BR, 2'b01, 0);
        step(0, 0, 0, 1, 32'h10, 1, IA, 32'h18, 32'h14, IA, 2'b01, 0);
        step(0, 0, 0, 1, 32'h10, 1, IA, 32'h1C, 32'h18, IA, 2'b01, 0);
        step(0, 1, 32'h10, 0, 0, 0, IA, 32'h10, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h08, 32'h10, BR, 2'b11, 1);
        // three taken updates on entry of 0x30 saturate at 11
        step(0, 0, 0, 1, 32'h30, 1, IC, 32'h0C, 32'h08, IC, 2'b01, 0);
        step(0, 0, 0, 1, 32'h30, 1, IA, 32'h10, 32'h0C, IA, 2'b01, 0);
        step(0, 0, 0, 1, 32'h30, 1, IA, 32'h14, 32'h10, IA, 2'b11, 0);
        step(0, 1, 32'h30, 0, 0, 0, IA, 32'h30, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 1, 32'h30, 0, BR, 32'h28, 32'h30, BR, 2'b11, 1);
        // four not-taken updates saturate at 00
        step(0, 0, 0, 1, 32'h30, 0, IA, 32'h2C, 32'h28, IA, 2'b01, 0);
        step(0, 0, 0, 1, 32'h30, 0, IA, 32'h30, 32'h2C, IA, 2'b01, 0);
        step(0, 0, 0, 1, 32'h30, 0, BR, 32'h34, 32'h30, BR, 2'b00, 0);
        step(0, 1, 32'h30, 0, 0, 0, IA, 32'h30, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h34, 32'h30, BR, 2'b00, 0);
        // JAL at 0x20, entry untouched
        step(0, 1, 32'h20, 0, 0, 0, IA, 32'h20, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, JL, 32'h120, 32'h20, JL, 2'b01, 1);
        step(0, 1, 32'h20, 0, 0, 0, IA, 32'h20, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h24, 32'h20, BR, 2'b01, 0);
        // stall at PC 0x08, BHT still trains, redirect overrides stall
        step(0, 1, 32'h04, 0, 0, 0, IA, 32'h04, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, IB, 32'h08, 32'h04, IB, 2'b01, 0);
        step(1, 0, 0, 1, 32'h20, 1, IC, 32'h08, 32'h04, IB, 2'b01, 0);
        step(1, 0, 0, 0, 0, 0, IC, 32'h08, 32'h04, IB, 2'b01, 0);
        step(1, 0, 0, 0, 0, 0, IC, 32'h08, 32'h04, IB, 2'b01, 0);
        step(1, 1, 32'h40, 0, 0, 0, IC, 32'h40, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h44, 32'h40, BR, 2'b01, 0);
        step(0, 1, 32'h20, 0, 0, 0, IA, 32'h20, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h18, 32'h20, BR, 2'b10, 1);
        // PC wrap-around
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, IA, 32'hFFFF_FFFC, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, IA, 32'h00, 32'hFFFF_FFFC, IA, 2'b01, 0);
        // mid-run reset clears BHT; same-cycle update/fetch collision on 0x10
        reset_mid();
        step(0, 0, 0, 0, 0, 0, IA, 32'h04, 32'h00, IA, 2'b01, 0);
        step(0, 1, 32'h10, 0, 0, 0, IA, 32'h10, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 1, 32'h10, 1, BR, 32'h14, 32'h10, BR, 2'b01, 0);
        step(0, 1, 32'h10, 0, 0, 0, IA, 32'h10, 32'h00, NOP, 2'b00, 0);
        step(0, 0, 0, 0, 0, 0, BR, 32'h08, 32'h10, BR, 2'b10, 1);

        for (int i = 0; i < 10 && expq.size() != 0; i++) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
